// File: rtl/cl_video_decoder.sv
// Camera Link Base-config decoder: unpacks ports A/B/C from the 28-bit channel word and drives
// a registered video bus, measures frame geometry and flags sync errors.
module cl_video_decoder #(
    parameter int VID_DATA_SIZE = 24,
    parameter int CNT_WIDTH     = 16,
    parameter int USE_DVAL      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [27:0]              Data,
    input  logic [1:0]               cfg_mode,
    input  logic                     err_clr,
    output logic                     vid_active_video,
    output logic [VID_DATA_SIZE-1:0] vid_data,
    output logic                     vid_hblank,
    output logic                     vid_vblank,
    output logic                     vid_sof,
    output logic                     vid_eol,
    output logic                     locked,
    output logic [CNT_WIDTH-1:0]     frame_width,
    output logic [CNT_WIDTH-1:0]     frame_height,
    output logic [CNT_WIDTH-1:0]     frame_count,
    output logic                     err_line_len,
    output logic                     err_lval_no_fval
);

    typedef enum logic [1:0] {
        UNSYNC,
        IDLE,
        FRAME
    } state_t;

    state_t state, state_next;

    logic [27:0] s1_data;
    logic        s1_valid;
    logic [7:0]  s1_a, s1_b, s1_c;

    logic        s2_valid, s2_lval, s2_fval, s2_dval;
    logic [7:0]  s2_a, s2_b, s2_c;

    logic [1:0]           mode_reg, mode_eff;
    logic                 sof_armed, prev_lval, first_seen;
    logic [CNT_WIDTH-1:0] pix_cnt, line_cnt, first_len;

    logic        frame_start, frame_end, beat_active, next_cont;
    logic        line_end, len_mismatch, lnf_event, synced_beat;
    logic [23:0] pix24;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign s1_a = {s1_data[5], s1_data[27], s1_data[6], s1_data[4:0]};
    assign s1_b = {s1_data[11], s1_data[10], s1_data[14:12], s1_data[9:7]};
    assign s1_c = {s1_data[17], s1_data[16], s1_data[22:18], s1_data[15]};

    // The valid bits keep the FSM from reading the cleared pipeline as a real FVAL=0 beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_lval  <= 1'b0;
            s2_fval  <= 1'b0;
            s2_dval  <= 1'b0;
            s2_a     <= '0;
            s2_b     <= '0;
            s2_c     <= '0;
        end else begin
            s1_data  <= Data;
            s1_valid <= 1'b1;
            s2_valid <= s1_valid;
            s2_lval  <= s1_data[24];
            s2_fval  <= s1_data[25];
            s2_dval  <= s1_data[26];
            s2_a     <= s1_a;
            s2_b     <= s1_b;
            s2_c     <= s1_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= UNSYNC;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (s2_valid) begin
            case (state)
                UNSYNC:  if (!s2_fval) state_next = IDLE;
                IDLE:    if (s2_fval)  state_next = FRAME;
                FRAME:   if (!s2_fval) state_next = IDLE;
                default: state_next = UNSYNC;
            endcase
        end
    end

    assign locked       = (state != UNSYNC);
    assign synced_beat  = s2_valid && (state != UNSYNC);
    assign frame_start  = s2_valid && (state == IDLE) && s2_fval;
    assign frame_end    = s2_valid && (state == FRAME) && !s2_fval;
    assign beat_active  = s2_valid && ((state == FRAME) || frame_start) && s2_fval && s2_lval
                          && ((USE_DVAL == 0) || s2_dval);
    // The beat behind in S1 is the look-ahead; DVAL is deliberately ignored here.
    assign next_cont    = s1_data[25] && s1_data[24];
    assign mode_eff     = (state == IDLE) ? cfg_mode : mode_reg;
    assign line_end     = s2_valid && (state == FRAME) && prev_lval && !s2_lval && (pix_cnt != '0);
    assign len_mismatch = line_end && first_seen && (pix_cnt != first_len);
    assign lnf_event    = s2_valid && s2_lval && !s2_fval;

    always_comb begin
        pix24 = '0;
        case (mode_eff)
            2'd0:    pix24 = {16'h0000, s2_a};
            2'd1:    pix24 = {8'h00, s2_a, s2_b};
            2'd2:    pix24 = {s2_a, s2_b, s2_c};
            default: pix24 = {8'h00, s2_b, s2_a};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_reg     <= '0;
            sof_armed    <= 1'b0;
            prev_lval    <= 1'b0;
            first_seen   <= 1'b0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            first_len    <= '0;
            frame_width  <= '0;
            frame_height <= '0;
            frame_count  <= '0;
        end else begin
            if (s2_valid) prev_lval <= s2_lval;
            if (frame_start) begin
                mode_reg   <= cfg_mode;
                sof_armed  <= !beat_active;
                pix_cnt    <= beat_active ? CNT_WIDTH'(1) : '0;
                line_cnt   <= '0;
                first_len  <= '0;
                first_seen <= 1'b0;
            end else if (s2_valid && (state == FRAME)) begin
                if (beat_active)   pix_cnt <= sat_inc(pix_cnt);
                else if (!s2_lval) pix_cnt <= '0;
                if (beat_active) sof_armed <= 1'b0;
                if (line_end) begin
                    line_cnt <= sat_inc(line_cnt);
                    if (!first_seen) begin
                        first_len  <= pix_cnt;
                        first_seen <= 1'b1;
                    end
                end
                // A line closed by the same beat that closes the frame still counts.
                if (frame_end) begin
                    sof_armed    <= 1'b0;
                    frame_width  <= first_seen ? first_len : (line_end ? pix_cnt : '0);
                    frame_height <= line_end ? sat_inc(line_cnt) : line_cnt;
                    frame_count  <= frame_count + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_line_len     <= 1'b0;
            err_lval_no_fval <= 1'b0;
        end else begin
            err_line_len     <= len_mismatch || (err_line_len && !err_clr);
            err_lval_no_fval <= lnf_event || (err_lval_no_fval && !err_clr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_active_video <= 1'b0;
            vid_data         <= '0;
            vid_hblank       <= 1'b1;
            vid_vblank       <= 1'b1;
            vid_sof          <= 1'b0;
            vid_eol          <= 1'b0;
        end else begin
            vid_active_video <= beat_active;
            vid_data         <= beat_active ? VID_DATA_SIZE'(pix24) : '0;
            vid_hblank       <= !(synced_beat && s2_lval);
            vid_vblank       <= !(synced_beat && s2_fval);
            vid_sof          <= beat_active && (sof_armed || frame_start);
            vid_eol          <= beat_active && !next_cont;
        end
    end

endmodule
